// File: rtl/spi_flash_reader.sv
// SPI flash reader: issues a 0x03 READ with a 24-bit address over a mode-0 link
// and returns one little-endian 32-bit word per accepted request.
//
// state | meaning
// IDLE  | chip select high, ready for a request
// CMD   | shifting out the 0x03 opcode, MSB first
// ADDR  | shifting out the captured 24-bit address, MSB first
// DATA  | shifting in 32 bits of read data
// GAP   | chip select held high before the next request
module spi_flash_reader #(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned CS_HIGH = 2
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    // The IDLE cycle ahead of the next acceptance also keeps chip select high,
    // so GAP only covers the remainder of the CS_HIGH window (at least one clock).
    localparam int unsigned GAP_LEN  = (CS_HIGH > 1) ? CS_HIGH - 1 : 1;
    localparam logic [7:0] GAP_LOAD = 8'(GAP_LEN - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_alive;
    logic [7:0]  r_div;
    logic [5:0]  r_bit;
    logic [30:0] r_tx;
    logic [30:0] r_rx;
    logic        r_csb;
    logic        r_sck;
    logic        r_io0;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;

    logic        w_accept;
    logic        w_shifting;
    logic        w_tc;
    logic        w_bit_end;
    logic        w_seg_done;
    logic [31:0] w_rx_nxt;
    logic [31:0] w_rx_word;

    assign req_ready  = r_alive && (r_state == IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_shifting = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);
    assign w_tc       = (r_div == 8'd0);
    assign w_bit_end  = w_shifting && w_tc && r_sck;
    assign w_seg_done = w_bit_end && (r_bit == 6'd0);
    assign w_rx_nxt   = {r_rx, flash_io1};
    // First byte on the wire lands in the low byte of the response.
    assign w_rx_word  = {w_rx_nxt[7:0], w_rx_nxt[15:8], w_rx_nxt[23:16], w_rx_nxt[31:24]};

    assign flash_csb = r_csb;
    assign flash_clk = r_sck;
    assign flash_io0 = r_io0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = CMD;
            CMD:     if (w_seg_done) w_state_nxt = ADDR;
            ADDR:    if (w_seg_done) w_state_nxt = DATA;
            DATA:    if (w_seg_done) w_state_nxt = GAP;
            GAP:     if (w_tc)       w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_alive     <= 1'b0;
            r_div       <= 8'd0;
            r_bit       <= 6'd0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_csb       <= 1'b1;
            r_sck       <= 1'b0;
            r_io0       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_alive     <= 1'b1;
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_csb <= 1'b0;
                r_sck <= 1'b0;
                r_io0 <= CMD_READ[7];
                r_tx  <= {CMD_READ[6:0], req_addr};
                r_div <= DIV_LOAD;
                r_bit <= 6'd7;
            end else if (w_shifting) begin
                if (!w_tc) begin
                    r_div <= r_div - 8'd1;
                end else if (!r_sck) begin
                    r_sck <= 1'b1;
                    r_div <= DIV_LOAD;
                end else begin
                    // End of the high phase: sample MISO, start the next bit.
                    r_sck <= 1'b0;
                    r_div <= DIV_LOAD;
                    r_bit <= r_bit - 6'd1;
                    r_tx  <= {r_tx[29:0], 1'b0};
                    r_io0 <= (r_state == DATA) ? 1'b0 : r_tx[30];
                    if (r_state == DATA) begin
                        r_rx <= w_rx_nxt[30:0];
                    end
                    if (r_bit == 6'd0) begin
                        case (r_state)
                            CMD: r_bit <= 6'd23;
                            ADDR: begin
                                r_bit <= 6'd31;
                                r_io0 <= 1'b0;
                            end
                            DATA: begin
                                r_bit       <= 6'd0;
                                r_csb       <= 1'b1;
                                r_div       <= GAP_LOAD;
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= w_rx_word;
                            end
                            default: ;
                        endcase
                    end
                end
            end else if ((r_state == GAP) && !w_tc) begin
                r_div <= r_div - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (divider 1 and 3) each talking to a
// behavioural SPI flash whose byte at address a is a[7:0]^a[15:8]^a[23:16].
module tb_spi_flash_reader;

    localparam int DIV0 = 1;
    localparam int DIV1 = 3;
    localparam int CSH  = 2;
    localparam logic [7:0] RD_CMD = 8'h03;

    logic        clock = 1'b0;
    logic        resetb;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [23:0] req_addr  [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_data  [2];
    logic        flash_csb [2];
    logic        flash_clk [2];
    logic        flash_io0 [2];
    logic        flash_io1 [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    spi_flash_reader #(.CLK_DIV(DIV0), .CS_HIGH(CSH)) dut0 (
        .clock(clock), .resetb(resetb),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .flash_csb(flash_csb[0]), .flash_clk(flash_clk[0]),
        .flash_io0(flash_io0[0]), .flash_io1(flash_io1[0])
    );

    spi_flash_reader #(.CLK_DIV(DIV1), .CS_HIGH(CSH)) dut1 (
        .clock(clock), .resetb(resetb),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .flash_csb(flash_csb[1]), .flash_clk(flash_clk[1]),
        .flash_io0(flash_io0[1]), .flash_io1(flash_io1[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [31:0] w;
        logic [23:0] p;
        for (int i = 0; i < 4; i++) begin
            p = a + 24'(i);
            w[8*i +: 8] = mem_byte(p);
        end
        return w;
    endfunction

    function automatic int div_of(input int g);
        return (g == 0) ? DIV0 : DIV1;
    endfunction

    // Flash model and protocol monitor, sampled mid-cycle.
    int          rise_cnt [2] = '{0, 0};
    int          fall_cnt [2] = '{0, 0};
    int          rsp_cnt  [2] = '{0, 0};
    int          rsp_cyc  [2] = '{0, 0};
    int          run      [2] = '{0, 0};
    logic [31:0] rsp_last [2] = '{0, 0};
    logic [31:0] mosi_cur [2] = '{0, 0};
    logic [31:0] mosi_last[2] = '{0, 0};
    logic        prev_csb [2] = '{1'b1, 1'b1};
    logic        prev_sck [2] = '{1'b0, 1'b0};
    logic        prev_io0 [2] = '{1'b0, 1'b0};
    int          mk;
    logic [7:0]  mb;

    initial begin
        flash_io1[0] = 1'b0;
        flash_io1[1] = 1'b0;
    end

    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (rsp_valid[g] === 1'b1) begin
                rsp_cnt[g]++;
                rsp_last[g] = rsp_data[g];
                rsp_cyc[g]  = cyc;
            end
            if (flash_csb[g] === 1'b0) begin
                if (prev_csb[g]) begin
                    fall_cnt[g]++;
                    rise_cnt[g] = 0;
                    mosi_cur[g] = 0;
                    run[g]      = 1;
                end else begin
                    if (flash_io0[g] !== prev_io0[g])
                        chk($sformatf("io0_moved_off_fall%0d", g), {30'd0, prev_sck[g], flash_clk[g]}, 32'd2);
                    if (flash_clk[g] !== prev_sck[g]) begin
                        chk($sformatf("sck_phase%0d", g), 32'(run[g]), 32'(div_of(g)));
                        run[g] = 1;
                    end else begin
                        run[g]++;
                    end
                end
                if (flash_clk[g] && !prev_sck[g]) begin
                    if (rise_cnt[g] < 32) mosi_cur[g] = {mosi_cur[g][30:0], flash_io0[g]};
                    rise_cnt[g]++;
                    if (rise_cnt[g] == 32) mosi_last[g] = mosi_cur[g];
                end
                if (!flash_clk[g] && prev_sck[g]) begin
                    if (rise_cnt[g] >= 32 && rise_cnt[g] < 64) begin
                        mk = rise_cnt[g] - 32;
                        mb = mem_byte(mosi_last[g][23:0] + 24'(mk / 8));
                        flash_io1[g] = mb[7 - (mk % 8)];
                    end else begin
                        flash_io1[g] = 1'b0;
                    end
                end
            end else begin
                if (!prev_csb[g] && resetb === 1'b1)
                    chk($sformatf("sck_rises_per_window%0d", g), 32'(rise_cnt[g]), 32'd64);
                if (resetb === 1'b1) begin
                    chk($sformatf("io0_idle%0d", g), {31'd0, flash_io0[g]}, 32'd0);
                    chk($sformatf("sck_idle%0d", g), {31'd0, flash_clk[g]}, 32'd0);
                end
                flash_io1[g] = 1'b0;
            end
            prev_csb[g] = (flash_csb[g] !== 1'b0);
            prev_sck[g] = (flash_clk[g] === 1'b1);
            prev_io0[g] = flash_io0[g];
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_ready(input int g, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (req_ready[g] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk($sformatf("ready_in_time%0d", g), {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_rsp(input int g, input int n0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rsp_cnt[g] > n0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk($sformatf("rsp_in_time%0d", g), {31'd0, ok}, 32'd1);
    endtask

    task automatic do_read(input int g, input logic [23:0] a);
        int n0;
        int c0;
        bit ok;
        wait_ready(g, ok);
        n0 = rsp_cnt[g];
        req_valid[g] = 1'b1;
        req_addr[g]  = a;
        c0 = cyc;
        step();
        req_valid[g] = 1'b0;
        req_addr[g]  = 24'($urandom);
        wait_rsp(g, n0, ok);
        if (ok) begin
            chk($sformatf("rsp_data%0d", g), rsp_last[g], exp_word(a));
            chk($sformatf("mosi%0d", g), mosi_last[g], {RD_CMD, a});
            chk($sformatf("latency%0d", g), 32'(rsp_cyc[g] - c0), 32'(1 + 128 * div_of(g)));
        end
        step();
        step();
        chk($sformatf("rsp_pulse_count%0d", g), 32'(rsp_cnt[g] - n0), 32'd1);
        chk($sformatf("rsp_hold%0d", g), rsp_data[g], exp_word(a));
    endtask

    task automatic back_to_back();
        int n0;
        int f0;
        int hi;
        int rdy;
        bit ok;
        wait_ready(0, ok);
        n0 = rsp_cnt[0];
        f0 = fall_cnt[0];
        hi = 0;
        rdy = 0;
        req_valid[0] = 1'b1;
        req_addr[0]  = 24'h000004;
        step();
        req_addr[0]  = 24'h000008;
        for (int i = 0; i < 400; i++) begin
            step();
            if (fall_cnt[0] >= f0 + 2) break;
            if (flash_csb[0] === 1'b1) hi++;
            if (req_ready[0] === 1'b1) rdy++;
        end
        req_valid[0] = 1'b0;
        chk("b2b_starts", 32'(fall_cnt[0] - f0), 32'd2);
        chk("b2b_csb_high_clocks", 32'(hi), 32'(CSH));
        chk("b2b_ready_cycles", 32'(rdy), 32'd1);
        chk("b2b_first_count", 32'(rsp_cnt[0] - n0), 32'd1);
        chk("b2b_first", rsp_last[0], exp_word(24'h000004));
        wait_rsp(0, n0 + 1, ok);
        chk("b2b_second", rsp_last[0], exp_word(24'h000008));
    endtask

    task automatic busy_ignore();
        int n0;
        int f0;
        bit ok;
        logic [23:0] a;
        a = 24'($urandom);
        wait_ready(0, ok);
        n0 = rsp_cnt[0];
        f0 = fall_cnt[0];
        req_valid[0] = 1'b1;
        req_addr[0]  = a;
        step();
        req_valid[0] = 1'b0;
        repeat (80) step();
        chk("busy_ready_low", {31'd0, req_ready[0]}, 32'd0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 24'h000020;
        step();
        req_valid[0] = 1'b0;
        wait_rsp(0, n0, ok);
        repeat (150) step();
        chk("busy_rsp_count", 32'(rsp_cnt[0] - n0), 32'd1);
        chk("busy_starts", 32'(fall_cnt[0] - f0), 32'd1);
        chk("busy_data", rsp_last[0], exp_word(a));
    endtask

    task automatic reset_abort();
        int n0;
        bit ok;
        wait_ready(0, ok);
        n0 = rsp_cnt[0];
        req_valid[0] = 1'b1;
        req_addr[0]  = 24'h000123;
        step();
        req_valid[0] = 1'b0;
        repeat (39) step();
        #2;
        resetb = 1'b0;
        #1;
        chk("abort_csb", {31'd0, flash_csb[0]}, 32'd1);
        chk("abort_sck", {31'd0, flash_clk[0]}, 32'd0);
        chk("abort_io0", {31'd0, flash_io0[0]}, 32'd0);
        chk("abort_ready", {31'd0, req_ready[0]}, 32'd0);
        chk("abort_rsp_data", rsp_data[0], 32'd0);
        repeat (5) step();
        chk("abort_no_rsp", 32'(rsp_cnt[0] - n0), 32'd0);
        resetb = 1'b1;
        chk("abort_ready_before_edge", {31'd0, req_ready[0]}, 32'd0);
        step();
        chk("abort_ready_after_edge", {31'd0, req_ready[0]}, 32'd1);
        do_read(0, 24'h000000);
        chk("abort_reread", rsp_last[0], 32'h03020100);
    endtask

    initial begin
        resetb = 1'b0;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0;
            req_addr[g]  = 24'd0;
        end
        repeat (3) step();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_csb%0d", g), {31'd0, flash_csb[g]}, 32'd1);
            chk($sformatf("rst_sck%0d", g), {31'd0, flash_clk[g]}, 32'd0);
            chk($sformatf("rst_io0%0d", g), {31'd0, flash_io0[g]}, 32'd0);
            chk($sformatf("rst_ready%0d", g), {31'd0, req_ready[g]}, 32'd0);
            chk($sformatf("rst_rsp_valid%0d", g), {31'd0, rsp_valid[g]}, 32'd0);
            chk($sformatf("rst_rsp_data%0d", g), rsp_data[g], 32'd0);
        end
        resetb = 1'b1;
        chk("ready_before_first_edge", {31'd0, req_ready[0]}, 32'd0);
        step();
        chk("ready_after_first_edge0", {31'd0, req_ready[0]}, 32'd1);
        chk("ready_after_first_edge1", {31'd0, req_ready[1]}, 32'd1);

        do_read(0, 24'h000010);
        chk("single_word", rsp_last[0], 32'h13121110);
        do_read(1, 24'h0000F0);
        chk("div3_word", rsp_last[1], 32'hF3F2F1F0);

        back_to_back();
        busy_ignore();
        reset_abort();

        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < 2; g++) begin
                do_read(g, (i == 0) ? 24'hFFFFFF : 24'($urandom));
            end
        end

        repeat (10) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
